// File: rtl/fetch_queue_pkg.sv
// Shared constants for the instruction fetch queue.
package fetch_queue_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [31:0] NOP_INSTR = 32'h00000013;
   // Low two bits of every 32-bit (non-compressed) RV32I encoding.
   localparam logic [1:0] RVI_LEN_BITS = 2'b11;

   function automatic logic is_illegal(input logic [1:0] low_bits);
      return low_bits != RVI_LEN_BITS;
   endfunction

endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// Generic circular FIFO with qualified push/pop, flush to empty and occupancy count.
module sync_fifo #(
   parameter int unsigned Width = 32,
   parameter int unsigned Depth = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           flush,
   input  logic                           push,
   input  logic [Width-1:0]               wdata,
   input  logic                           pop,
   output logic [Width-1:0]               rdata,
   output logic                           full,
   output logic                           empty,
   output logic [$clog2(Depth+1)-1:0]     count
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = $clog2(Depth + 1);

   logic [Width-1:0] mem [Depth];
   logic [PtrW-1:0]  head_q, tail_q;
   logic [CntW-1:0]  count_q, count_d;
   logic             push_en, pop_en;

   assign full    = (count_q == CntW'(Depth));
   assign empty   = (count_q == '0);
   assign push_en = push && !full && !flush;
   assign pop_en  = pop && !empty && !flush;
   assign rdata   = mem[head_q];
   assign count   = count_q;

   always_comb begin
      count_d = count_q;
      if (push_en && !pop_en) begin
         count_d = count_q + CntW'(1);
      end else if (pop_en && !push_en) begin
         count_d = count_q - CntW'(1);
      end
   end

   // Depth is a power of two, so pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (push_en) tail_q <= tail_q + PtrW'(1);
         if (pop_en)  head_q <= head_q + PtrW'(1);
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_en) mem[tail_q] <= wdata;
   end

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue: tags non-32-bit encodings and zeroes idle outputs.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned XLEN  = fetch_queue_pkg::XLEN
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   input  logic [XLEN-1:0]              in_pc,
   input  logic [XLEN-1:0]              in_instr,
   output logic                         in_ready,
   output logic                         out_valid,
   output logic [XLEN-1:0]              out_pc,
   output logic [XLEN-1:0]              out_instr,
   output logic                         out_illegal,
   input  logic                         out_ready,
   input  logic                         flush,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned EntryW = 2 * XLEN + 1;

   logic [EntryW-1:0] wdata, rdata;
   logic              full, empty;

   assign wdata = {is_illegal(in_instr[1:0]), in_pc, in_instr};

   sync_fifo #(
      .Width (EntryW),
      .Depth (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .push  (in_valid),
      .wdata (wdata),
      .pop   (out_ready),
      .rdata (rdata),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   assign in_ready  = !full;
   assign out_valid = !empty;

   always_comb begin
      out_illegal = 1'b0;
      out_pc      = '0;
      out_instr   = '0;
      if (out_valid) begin
         out_illegal = rdata[EntryW-1];
         out_pc      = rdata[2*XLEN-1:XLEN];
         out_instr   = rdata[XLEN-1:0];
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: cycle vector table plus streaming, flush and reset sequences.
module tb_fetch_queue;

   logic        clk = 1'b0;
   logic        reset, in_valid, in_ready, out_valid, out_illegal, out_ready, flush;
   logic [31:0] in_pc, in_instr, out_pc, out_instr;
   logic [2:0]  count;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   fetch_queue #(
      .DEPTH (4),
      .XLEN  (32)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_pc       (in_pc),
      .in_instr    (in_instr),
      .in_ready    (in_ready),
      .out_valid   (out_valid),
      .out_pc      (out_pc),
      .out_instr   (out_instr),
      .out_illegal (out_illegal),
      .out_ready   (out_ready),
      .flush       (flush),
      .count       (count)
   );

   typedef struct {
      logic        rst;
      logic        iv;
      logic [31:0] pc;
      logic [31:0] instr;
      logic        ordy;
      logic        fl;
      logic        e_valid;
      logic [31:0] e_pc;
      logic [31:0] e_instr;
      logic        e_ill;
      logic [2:0]  e_cnt;
      logic        e_rdy;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic rst, logic iv, logic [31:0] pc, logic [31:0] instr,
                               logic ordy, logic fl, logic ev, logic [31:0] epc,
                               logic [31:0] einstr, logic eill, logic [2:0] ecnt, logic erdy);
      vec_t v;
      v.rst = rst; v.iv = iv; v.pc = pc; v.instr = instr; v.ordy = ordy; v.fl = fl;
      v.e_valid = ev; v.e_pc = epc; v.e_instr = einstr; v.e_ill = eill;
      v.e_cnt = ecnt; v.e_rdy = erdy;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   // Apply one cycle of inputs, then sample 1 time unit after the rising edge.
   task automatic step(input logic rst, input logic iv, input logic [31:0] pc,
                       input logic [31:0] instr, input logic ordy, input logic fl);
      reset = rst; in_valid = iv; in_pc = pc; in_instr = instr; out_ready = ordy; flush = fl;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic ev, input logic [31:0] epc,
                          input logic [31:0] einstr, input logic eill, input logic [2:0] ecnt,
                          input logic erdy);
      chk({tag, ".out_valid"},   {31'b0, out_valid},   {31'b0, ev});
      chk({tag, ".out_pc"},      out_pc,               epc);
      chk({tag, ".out_instr"},   out_instr,            einstr);
      chk({tag, ".out_illegal"}, {31'b0, out_illegal}, {31'b0, eill});
      chk({tag, ".count"},       {29'b0, count},       {29'b0, ecnt});
      chk({tag, ".in_ready"},    {31'b0, in_ready},    {31'b0, erdy});
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_instr = '0; out_ready = 1'b0; flush = 1'b0;

      //           rst iv  pc      instr         ordy fl  | ev pc      instr         ill cnt rdy
      vecs.push_back(mk(1, 0, 32'h0,  32'h0,        0, 0,  0, 32'h0,  32'h0,        0, 0, 1));
      vecs.push_back(mk(0, 1, 32'h0,  32'h00500093, 0, 0,  1, 32'h0,  32'h00500093, 0, 1, 1));
      vecs.push_back(mk(0, 0, 32'h0,  32'h0,        1, 0,  0, 32'h0,  32'h0,        0, 0, 1));
      // Fill to DEPTH with decode stalled; head must hold.
      vecs.push_back(mk(0, 1, 32'h0,  32'h00000013, 0, 0,  1, 32'h0,  32'h00000013, 0, 1, 1));
      vecs.push_back(mk(0, 1, 32'h4,  32'h00100093, 0, 0,  1, 32'h0,  32'h00000013, 0, 2, 1));
      vecs.push_back(mk(0, 1, 32'h8,  32'h00200093, 0, 0,  1, 32'h0,  32'h00000013, 0, 3, 1));
      vecs.push_back(mk(0, 1, 32'hC,  32'h00000001, 0, 0,  1, 32'h0,  32'h00000013, 0, 4, 0));
      vecs.push_back(mk(0, 1, 32'h10, 32'h00300093, 0, 0,  1, 32'h0,  32'h00000013, 0, 4, 0));
      // Pop from full while 0x10 is still offered: push refused this cycle.
      vecs.push_back(mk(0, 1, 32'h10, 32'h00300093, 1, 0,  1, 32'h4,  32'h00100093, 0, 3, 1));
      vecs.push_back(mk(0, 0, 32'h0,  32'h0,        1, 0,  1, 32'h8,  32'h00200093, 0, 2, 1));
      vecs.push_back(mk(0, 0, 32'h0,  32'h0,        1, 0,  1, 32'hC,  32'h00000001, 1, 1, 1));
      vecs.push_back(mk(0, 0, 32'h0,  32'h0,        1, 0,  0, 32'h0,  32'h0,        0, 0, 1));
      // Illegal-bit tagging, then legal NOP replacing it at the head.
      vecs.push_back(mk(0, 1, 32'h20, 32'h00000001, 0, 0,  1, 32'h20, 32'h00000001, 1, 1, 1));
      vecs.push_back(mk(0, 1, 32'h24, 32'h00000013, 1, 0,  1, 32'h24, 32'h00000013, 0, 1, 1));
      vecs.push_back(mk(0, 0, 32'h0,  32'h0,        1, 0,  0, 32'h0,  32'h0,        0, 0, 1));

      foreach (vecs[i]) begin
         step(vecs[i].rst, vecs[i].iv, vecs[i].pc, vecs[i].instr, vecs[i].ordy, vecs[i].fl);
         chk_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_instr,
                 vecs[i].e_ill, vecs[i].e_cnt, vecs[i].e_rdy);
      end

      // Streaming: 10 words, push and pop every cycle, pointers wrap.
      step(1, 0, 32'h0, 32'h0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         logic [31:0] pc_i, instr_i;
         pc_i    = 32'(i) * 32'd4;
         instr_i = 32'h00000093 + (32'(i) << 20);
         step(0, 1, pc_i, instr_i, 1, 0);
         chk_all($sformatf("stream%0d", i), 1'b1, pc_i, instr_i, 1'b0, 3'd1, 1'b1);
      end
      step(0, 0, 32'h0, 32'h0, 1, 0);
      chk_all("stream_drain", 1'b0, 32'h0, 32'h0, 1'b0, 3'd0, 1'b1);

      // Flush beats a simultaneous push and pop.
      step(1, 0, 32'h0, 32'h0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 1, 32'h100 + 32'(i) * 32'd4, 32'h00000013, 0, 0);
      chk_all("flush_pre", 1'b1, 32'h100, 32'h00000013, 1'b0, 3'd3, 1'b1);
      step(0, 1, 32'h200, 32'h00000093, 1, 1);
      chk_all("flush", 1'b0, 32'h0, 32'h0, 1'b0, 3'd0, 1'b1);
      step(0, 0, 32'h0, 32'h0, 1, 0);
      chk_all("flush_after", 1'b0, 32'h0, 32'h0, 1'b0, 3'd0, 1'b1);
      step(0, 1, 32'h300, 32'h00A00093, 0, 0);
      chk_all("flush_repush", 1'b1, 32'h300, 32'h00A00093, 1'b0, 3'd1, 1'b1);

      // Reset mid-stream with a push in flight.
      step(0, 1, 32'h30, 32'h00000013, 0, 0);
      chk("rst_pre.count", {29'b0, count}, 32'd2);
      step(1, 1, 32'h38, 32'h00000013, 0, 0);
      chk_all("rst_mid", 1'b0, 32'h0, 32'h0, 1'b0, 3'd0, 1'b1);
      step(0, 1, 32'h40, 32'h00700093, 0, 0);
      chk_all("rst_push", 1'b1, 32'h40, 32'h00700093, 1'b0, 3'd1, 1'b1);
      step(0, 0, 32'h0, 32'h0, 1, 0);
      chk_all("rst_only", 1'b0, 32'h0, 32'h0, 1'b0, 3'd0, 1'b1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue between the instruction memory and the decode stage. Each cycle it captures one fetched instruction word and its PC from the fetch side, buffers up to DEPTH entries in a circular FIFO, and presents the oldest entry to decode under a valid/ready handshake. It flags non-32-bit encodings as illegal. A flush input discards all buffered entries on a control-flow redirect.

## Interface
- DEPTH, 4, number of entries; power of two, ≥ 2
- XLEN, 32, PC and instruction width
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  fetch side presents a word this cycle
- in_pc  input  XLEN  byte address of the word; low 2 bits are 0
- in_instr  input  XLEN  instruction word
- in_ready  output  1  queue accepts a push this cycle
- out_valid  output  1  head entry is valid
- out_pc  output  XLEN  head entry PC
- out_instr  output  XLEN  head entry instruction
- out_illegal  output  1  head entry has instr[1:0] != 2'b11
- out_ready  input  1  decode consumes the head this cycle
- flush  input  1  discard all entries and any push in this cycle
- count  output  $clog2(DEPTH+1)  number of valid entries

## Operation
- Storage: DEPTH entries of {pc, instr, illegal}, plus head pointer, tail pointer and count registers.
- Push: in_valid && in_ready && !flush. Writes at tail; tail advances modulo DEPTH. The illegal bit is computed at write time from in_instr[1:0].
- Pop: out_valid && out_ready && !flush. Head advances modulo DEPTH.
- in_ready = (count != DEPTH). It is combinational from count only and does not depend on out_ready, so there is no full-queue bypass.
- out_valid = (count != 0). out_pc, out_instr and out_illegal are read from the head entry. They are forced to 0 while out_valid = 0.
- Simultaneous push and pop: count is unchanged; both pointers advance.
- Push attempted when full: ignored and data is not written. The producer holds its word, and the fetch stage is responsible for stalling its PC.
- Pop attempted when empty: ignored.
- Flush has priority over push and pop in the same cycle. The next cycle has head = tail = 0 and count = 0, and the word presented with flush is dropped.
- Reset (any cycle, including mid-stream): head = tail = 0, count = 0. Storage contents are don't-care.

## Timing
- Reset values: out_valid 0, out_pc 0, out_instr 0, out_illegal 0, count 0, in_ready 1.
- Push-to-output latency: 1 cycle. A word accepted at edge N is visible on out_* after edge N, if the queue was empty.
- Throughput: 1 push and 1 pop per cycle sustained.
- out_* remain stable while out_valid && !out_ready && !flush.
- in_ready deasserts in the cycle after the DEPTH-th outstanding push, and reasserts in the cycle after the first pop from full.
- count updates on every clock edge as count + push − pop, or 0 on flush or reset.
- Pointer wrap: after DEPTH pushes, tail returns to 0. Ordering is preserved across wrap.

## Structure
- Shared package: XLEN, the NOP encoding 32'h00000013, and the RV32I "non-compressed" check constant 2'b11.
- One natural sub-module: sync_fifo, a generic circular buffer with push/pop/flush and count. fetch_queue wraps it and adds the illegal-bit generation and the output zeroing.

## Test plan
- Reset then a single push of pc=0x0, instr=0x00500093 -> next cycle out_valid=1, out_pc=0x0, out_instr=0x00500093, out_illegal=0, count=1. Pop -> out_valid=0 and outputs 0.
- Fill with out_ready=0 and pushes at pc 0x0, 0x4, 0x8, 0xC, then keep in_valid=1 with pc 0x10 -> count=4, in_ready=0, and 0x10 is not stored. Drain -> PCs come out in order 0x0..0xC.
- Streaming 10 words with in_valid=out_ready=1 every cycle -> count stays 1, outputs follow inputs with 1-cycle delay, and pointers wrap twice with no loss.
- Queue holding 3 entries, then flush=1 together with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, and nothing is popped to decode.
- Push of instr=0x00000001 -> out_illegal=1 when it reaches the head. The following instr 0x00000013 -> out_illegal=0.
- Reset asserted while count=2 and a push is in flight -> next cycle count=0 and in_ready=1. A subsequent push at pc=0x40 appears as the only entry.
